alu_pipe_seq: RTL and testbench

Parametrised successor to the team's 8-bit ALU. It has a WIDTH-bit datapath and a valid/ready handshake on both input and output. All results and flags are registered. A multi-cycle shift-add unsigned multiply runs under a small state machine. It sits between the operand fetch stage and the writeback stage, with back-pressure in both directions.

---
 rtl/alu_pipe_seq.sv | 240 ++++++++++++++++++++++++
 tb/tb_alu_pipe_seq.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe_seq.sv
// WIDTH-bit ALU with valid/ready handshakes on both sides and registered results/flags.
// Single-cycle ops load the output at accept; MUL runs WIDTH shift-add iterations first.
module alu_pipe_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             in_clk,
    input  logic             in_wdt_rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       alu_sel,
    input  logic [WIDTH-1:0] in_1,
    input  logic [WIDTH-1:0] in_2,
    input  logic             in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_alu,
    output logic             zero_flag,
    output logic             sign_flag,
    output logic             parity_flag,
    output logic             overflow_flag,
    output logic             carry_flag,
    output logic             Auxiliary_Carry_flag,
    output logic             out_illegal
);

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_e;

    typedef enum logic [4:0] {
        OP_ADD = 5'd0,
        OP_ADC = 5'd1,
        OP_SUB = 5'd2,
        OP_SBB = 5'd3,
        OP_AND = 5'd4,
        OP_OR  = 5'd5,
        OP_XOR = 5'd6,
        OP_NOT = 5'd7,
        OP_SHL = 5'd8,
        OP_SHR = 5'd9,
        OP_SAR = 5'd10,
        OP_ROL = 5'd11,
        OP_ROR = 5'd12,
        OP_CMP = 5'd13,
        OP_MUL = 5'd14,
        OP_INC = 5'd15,
        OP_DEC = 5'd16
    } op_e;

    localparam logic [SHW:0]   WIDTH_L  = (SHW+1)'(WIDTH);
    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH-1);

    state_e             state_q, state_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_alu_q, out_alu_d;
    logic [5:0]         flags_q, flags_d;
    logic               illegal_q, illegal_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [SHW-1:0]     cnt_q, cnt_d;

    logic [WIDTH-1:0]   opb;
    logic               cin;
    logic               is_sub;
    logic [WIDTH:0]     sum;
    logic               ovf;
    logic [SHW-1:0]     sh;
    logic [SHW:0]       sh_inv;
    logic [WIDTH:0]     sh_ext;
    logic [WIDTH-1:0]   rot;
    logic [WIDTH-1:0]   res;
    logic               c_f, v_f, a_f, ill;
    logic [5:0]         flg;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH-1:0]   mul_lo;
    logic               mul_hi;

    assign in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);

    always_comb begin
        opb    = in_2;
        cin    = in_carry;
        is_sub = 1'b0;
        case (alu_sel)
            OP_ADD:         cin = 1'b0;
            OP_SUB, OP_CMP: begin is_sub = 1'b1; cin = 1'b0; end
            OP_SBB:         is_sub = 1'b1;
            OP_INC:         begin opb = WIDTH'(1); cin = 1'b0; end
            OP_DEC:         begin opb = WIDTH'(1); cin = 1'b0; is_sub = 1'b1; end
            default:        ;
        endcase

        // Bit WIDTH of the extended difference is the borrow; the carry/borrow
        // across the nibble boundary is recovered from bit 4 of operands and result.
        if (is_sub) begin
            sum = {1'b0, in_1} - {1'b0, opb} - (WIDTH+1)'(cin);
            ovf = (in_1[WIDTH-1] != opb[WIDTH-1]) && (sum[WIDTH-1] != in_1[WIDTH-1]);
        end else begin
            sum = {1'b0, in_1} + {1'b0, opb} + (WIDTH+1)'(cin);
            ovf = (in_1[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1] != in_1[WIDTH-1]);
        end

        sh     = in_2[SHW-1:0];
        sh_inv = WIDTH_L - {1'b0, sh};
        sh_ext = '0;
        rot    = '0;
        res    = '0;
        c_f    = 1'b0;
        v_f    = 1'b0;
        a_f    = 1'b0;
        ill    = 1'b0;
        case (alu_sel)
            OP_ADD, OP_ADC, OP_SUB, OP_SBB, OP_INC, OP_DEC, OP_CMP: begin
                res = (alu_sel == OP_CMP) ? in_1 : sum[WIDTH-1:0];
                c_f = sum[WIDTH];
                v_f = ovf;
                a_f = in_1[4] ^ opb[4] ^ sum[4];
            end
            OP_AND: res = in_1 & in_2;
            OP_OR:  res = in_1 | in_2;
            OP_XOR: res = in_1 ^ in_2;
            OP_NOT: res = ~in_1;
            OP_SHL: begin
                sh_ext = {1'b0, in_1} << sh;
                res    = sh_ext[WIDTH-1:0];
                c_f    = sh_ext[WIDTH];
            end
            OP_SHR: begin
                sh_ext = {in_1, 1'b0} >> sh;
                res    = sh_ext[WIDTH:1];
                c_f    = sh_ext[0];
            end
            OP_SAR: begin
                sh_ext = $signed({in_1, 1'b0}) >>> sh;
                res    = sh_ext[WIDTH:1];
                c_f    = sh_ext[0];
            end
            OP_ROL: begin
                rot = (in_1 << sh) | (in_1 >> sh_inv);
                res = rot;
                c_f = (sh != '0) && rot[0];
            end
            OP_ROR: begin
                rot = (in_1 >> sh) | (in_1 << sh_inv);
                res = rot;
                c_f = (sh != '0) && rot[WIDTH-1];
            end
            OP_MUL:  ;
            default: ill = 1'b1;
        endcase
        flg = ill ? '0 : {~|res, res[WIDTH-1], ~^res, v_f, c_f, a_f};
    end

    always_comb begin
        acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
        mul_lo   = acc_step[WIDTH-1:0];
        mul_hi   = |acc_step[2*WIDTH-1:WIDTH];

        state_d     = state_q;
        out_valid_d = out_valid_q && !out_ready;
        out_alu_d   = out_alu_q;
        flags_d     = flags_q;
        illegal_d   = illegal_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        cnt_d       = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    if (alu_sel == OP_MUL) begin
                        state_d  = S_MUL;
                        acc_d    = '0;
                        mcand_d  = (2*WIDTH)'(in_1);
                        mplier_d = in_2;
                        cnt_d    = '0;
                    end else begin
                        out_valid_d = 1'b1;
                        out_alu_d   = res;
                        flags_d     = flg;
                        illegal_d   = ill;
                    end
                end
            end
            S_MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b1;
                    out_alu_d   = mul_lo;
                    flags_d     = {~|mul_lo, mul_lo[WIDTH-1], ~^mul_lo, mul_hi, mul_hi, 1'b0};
                    illegal_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge in_clk or negedge in_wdt_rst_n) begin
        if (!in_wdt_rst_n) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            out_alu_q   <= '0;
            flags_q     <= '0;
            illegal_q   <= 1'b0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_alu_q   <= out_alu_d;
            flags_q     <= flags_d;
            illegal_q   <= illegal_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid            = out_valid_q;
    assign out_alu              = out_alu_q;
    assign zero_flag            = flags_q[5];
    assign sign_flag            = flags_q[4];
    assign parity_flag          = flags_q[3];
    assign overflow_flag        = flags_q[2];
    assign carry_flag           = flags_q[1];
    assign Auxiliary_Carry_flag = flags_q[0];
    assign out_illegal          = illegal_q;

endmodule

// File: tb/tb_alu_pipe_seq.sv
// Scoreboard bench for alu_pipe_seq: one WIDTH=8 and one WIDTH=32 instance, selected by sel.
module tb_alu_pipe_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst8_n, rst32_n, sel;
    logic        in_valid, in_carry, out_ready;
    logic [4:0]  alu_sel;
    logic [63:0] in_1, in_2;

    logic        rdy8, rdy32, ov8, ov32, ill8, ill32;
    logic [7:0]  alu8;
    logic [31:0] alu32;
    logic [5:0]  fl8, fl32;

    logic        obs_ready, obs_valid, obs_ill;
    logic [63:0] obs_alu;
    logic [5:0]  obs_fl;

    assign obs_ready = sel ? rdy32 : rdy8;
    assign obs_valid = sel ? ov32 : ov8;
    assign obs_ill   = sel ? ill32 : ill8;
    assign obs_alu   = sel ? {32'd0, alu32} : {56'd0, alu8};
    assign obs_fl    = sel ? fl32 : fl8;

    alu_pipe_seq #(.WIDTH(8)) u_dut8 (
        .in_clk(clk), .in_wdt_rst_n(rst8_n),
        .in_valid(in_valid && !sel), .in_ready(rdy8),
        .alu_sel(alu_sel), .in_1(in_1[7:0]), .in_2(in_2[7:0]), .in_carry(in_carry),
        .out_valid(ov8), .out_ready(out_ready), .out_alu(alu8),
        .zero_flag(fl8[5]), .sign_flag(fl8[4]), .parity_flag(fl8[3]),
        .overflow_flag(fl8[2]), .carry_flag(fl8[1]), .Auxiliary_Carry_flag(fl8[0]),
        .out_illegal(ill8)
    );

    alu_pipe_seq #(.WIDTH(32)) u_dut32 (
        .in_clk(clk), .in_wdt_rst_n(rst32_n),
        .in_valid(in_valid && sel), .in_ready(rdy32),
        .alu_sel(alu_sel), .in_1(in_1[31:0]), .in_2(in_2[31:0]), .in_carry(in_carry),
        .out_valid(ov32), .out_ready(out_ready), .out_alu(alu32),
        .zero_flag(fl32[5]), .sign_flag(fl32[4]), .parity_flag(fl32[3]),
        .overflow_flag(fl32[2]), .carry_flag(fl32[1]), .Auxiliary_Carry_flag(fl32[0]),
        .out_illegal(ill32)
    );

    typedef struct {
        logic [63:0] res;
        logic z, s, p, v, c, ac, ill;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    function automatic longint sx(input int w, input logic [63:0] x);
        if (x[w-1]) return longint'(x) - (longint'(1) <<< w);
        return longint'(x);
    endfunction

    // Reference model: bit-serial shifts, integer arithmetic for sums and flags.
    function automatic exp_t model(input int w, input logic [4:0] op, input logic [63:0] a_in,
                                   input logic [63:0] b_in, input logic cin);
        exp_t        e;
        logic [63:0] m, a, b, bb, r, t, msb;
        logic        cc, c;
        longint      sr, smax, smin;
        int          amt;
        m    = (64'd1 << w) - 64'd1;
        msb  = 64'd1 << (w - 1);
        smax = (longint'(1) <<< (w - 1)) - 1;
        smin = -(longint'(1) <<< (w - 1));
        a    = a_in & m;
        b    = b_in & m;
        amt  = int'(b & 64'(w - 1));
        bb   = (op == 5'd15 || op == 5'd16) ? 64'd1 : b;
        cc   = (op == 5'd1 || op == 5'd3) ? cin : 1'b0;
        r = a; c = 1'b0; e.v = 1'b0; e.ac = 1'b0; e.ill = 1'b0;
        case (op)
            5'd0, 5'd1, 5'd15: begin
                t    = a + bb + 64'(cc);
                r    = t & m;
                c    = t[w];
                e.ac = ((a & 64'd15) + (bb & 64'd15) + 64'(cc)) > 64'd15;
                sr   = sx(w, a) + sx(w, bb) + longint'(cc);
                e.v  = (sr > smax) || (sr < smin);
            end
            5'd2, 5'd3, 5'd13, 5'd16: begin
                t    = a - bb - 64'(cc);
                r    = (op == 5'd13) ? a : (t & m);
                c    = a < (bb + 64'(cc));
                e.ac = (a & 64'd15) < ((bb & 64'd15) + 64'(cc));
                sr   = sx(w, a) - sx(w, bb) - longint'(cc);
                e.v  = (sr > smax) || (sr < smin);
            end
            5'd4: r = a & b;
            5'd5: r = a | b;
            5'd6: r = a ^ b;
            5'd7: r = ~a & m;
            5'd8:  for (int i = 0; i < amt; i++) begin c = r[w-1]; r = (r << 1) & m; end
            5'd9:  for (int i = 0; i < amt; i++) begin c = r[0]; r = r >> 1; end
            5'd10: for (int i = 0; i < amt; i++) begin c = r[0]; r = (r >> 1) | (r & msb); end
            5'd11: for (int i = 0; i < amt; i++) begin c = r[w-1]; r = ((r << 1) & m) | 64'(c); end
            5'd12: for (int i = 0; i < amt; i++) begin c = r[0]; r = (r >> 1) | (c ? msb : 64'd0); end
            5'd14: begin
                t   = a * b;
                r   = t & m;
                c   = (t >> w) != 64'd0;
                e.v = c;
            end
            default: e.ill = 1'b1;
        endcase
        if (e.ill) begin
            e.res = '0; e.z = 1'b0; e.s = 1'b0; e.p = 1'b0; e.v = 1'b0; e.c = 1'b0; e.ac = 1'b0;
        end else begin
            e.res = r;
            e.c   = c;
            e.z   = (r == 64'd0);
            e.s   = r[w-1];
            e.p   = ~^r;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_head(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s: observed=result expected=no result (scoreboard empty)", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_alu"}, obs_alu, e.res);
            chk({tag, "_flags"}, 64'(obs_fl), 64'({e.z, e.s, e.p, e.v, e.c, e.ac}));
            chk({tag, "_ill"}, 64'(obs_ill), 64'(e.ill));
        end
    endtask

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic issue(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic c, input bit push);
        int n;
        alu_sel  = op;
        in_1     = a;
        in_2     = b;
        in_carry = c;
        in_valid = 1'b1;
        #1;
        n = 0;
        while (!obs_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!obs_ready) begin
            n_checks++;
            n_fail++;
            $error("FAIL issue_timeout: observed in_ready=0 expected=1");
        end
        if (push) sb.push_back(model(sel ? 32 : 8, op, a, b, c));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_1     = {$urandom, $urandom};
        in_2     = {$urandom, $urandom};
        in_carry = 1'(~c);
        @(negedge clk);
    endtask

    task automatic collect(input string tag);
        int n;
        n = 0;
        while (!obs_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!obs_valid) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s_timeout: observed out_valid=0 expected=1", tag);
        end else begin
            check_head(tag);
        end
        @(negedge clk);
    endtask

    task automatic reset_chk(input string tag);
        chk({tag, "_valid"}, 64'(obs_valid), 64'd0);
        chk({tag, "_alu"}, obs_alu, 64'd0);
        chk({tag, "_flags"}, 64'(obs_fl), 64'd0);
        chk({tag, "_ill"}, 64'(obs_ill), 64'd0);
        chk({tag, "_ready"}, 64'(obs_ready), 64'd1);
    endtask

    initial begin
        logic [4:0] rop;
        bit         seen;
        rst8_n = 1'b0; rst32_n = 1'b0; sel = 1'b0;
        in_valid = 1'b0; in_carry = 1'b0; out_ready = 1'b1;
        alu_sel = '0; in_1 = '0; in_2 = '0;
        repeat (2) @(negedge clk);
        reset_chk("rst8");
        sel = 1'b1;
        #1;
        reset_chk("rst32");
        sel = 1'b0;
        @(negedge clk);
        rst8_n = 1'b1; rst32_n = 1'b1;
        @(negedge clk);

        issue(5'd1, 64'h7F, 64'h09, 1'b1, 1'b1);
        chk("adc_literal", obs_alu, 64'h89);
        collect("adc");
        issue(5'd2, 64'h00, 64'h01, 1'b0, 1'b1);
        collect("sub");

        issue(5'd14, 64'd15, 64'd17, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            chk("mul8_busy_ready", 64'(obs_ready), 64'd0);
            chk("mul8_busy_valid", 64'(obs_valid), 64'd0);
            @(negedge clk);
        end
        chk("mul8_done_valid", 64'(obs_valid), 64'd1);
        collect("mul8_a");
        issue(5'd14, 64'd16, 64'd16, 1'b0, 1'b1);
        collect("mul8_b");

        out_ready = 1'b0;
        issue(5'd0, 64'd3, 64'd4, 1'b0, 1'b1);
        alu_sel = 5'd0; in_1 = 64'd5; in_2 = 64'd6; in_carry = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_hold_alu", obs_alu, 64'd7);
            chk("bp_hold_valid", 64'(obs_valid), 64'd1);
            chk("bp_hold_ready", 64'(obs_ready), 64'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(obs_ready), 64'd1);
        check_head("bp_first");
        sb.push_back(model(8, 5'd0, 64'd5, 64'd6, 1'b0));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_nogap_valid", 64'(obs_valid), 64'd1);
        check_head("bp_second");
        @(negedge clk);

        for (int i = 0; i < 30; i++) begin
            rop = 5'($urandom_range(0, 31));
            issue(rop, {32'd0, $urandom}, {32'd0, $urandom}, 1'($urandom), 1'b1);
            collect("rnd8");
        end

        sel = 1'b1;
        @(negedge clk);
        issue(5'd0, 64'h12345678, 64'h11111111, 1'b0, 1'b1);
        collect("add32");
        issue(5'd14, 64'hDEADBEEF, 64'h01234567, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst32_n = 1'b0;
        #1;
        reset_chk("mul_abort");
        @(negedge clk);
        rst32_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (obs_valid) seen = 1'b1;
        end
        chk("abort_no_valid", 64'(seen), 64'd0);
        chk("abort_ready", 64'(obs_ready), 64'd1);

        issue(5'd10, 64'h80000000, 64'd4, 1'b0, 1'b1);
        chk("sar_literal", obs_alu, 64'hF8000000);
        collect("sar32");
        issue(5'd11, 64'h80000001, 64'd1, 1'b0, 1'b1);
        chk("rol_literal", obs_alu, 64'h00000003);
        collect("rol32");
        issue(5'd31, 64'h12345678, 64'h9ABCDEF0, 1'b1, 1'b1);
        chk("illegal_literal", 64'(obs_ill), 64'd1);
        collect("ill32");
        issue(5'd14, 64'hFFFFFFFF, 64'hFFFFFFFF, 1'b0, 1'b1);
        collect("mul32");

        for (int i = 0; i < 30; i++) begin
            rop = 5'($urandom_range(0, 31));
            issue(rop, {32'd0, $urandom}, {32'd0, $urandom}, 1'($urandom), 1'b1);
            collect("rnd32");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
